// File: rtl/ladybird_arb_pkg.sv
// ladybird_arb_pkg: shared arbiter state type and the round-robin pick function.
package ladybird_arb_pkg;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [ARB_IDX_W-1:0] idx;
    } rr_pick_t;

    // The loop has a fixed trip count; entries beyond n_req are masked off.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                         input logic [ARB_IDX_W-1:0] last_grant,
                                         input int n_req);
        rr_pick_t r;
        int i;
        r = '0;
        for (int k = 1; k <= ARB_MAX_REQ; k++) begin
            i = (int'(last_grant) + k) % n_req;
            if (k <= n_req && !r.found && req[i]) begin
                r.found = 1'b1;
                r.idx   = ARB_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ladybird_rr_picker.sv
// ladybird_rr_picker: combinational round-robin selection starting after last_grant.
module ladybird_rr_picker
    import ladybird_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [ID_W-1:0]  pick,
    output logic             found
);

    rr_pick_t r;

    always_comb begin
        r     = rr_pick(ARB_MAX_REQ'(req), ARB_IDX_W'(last_grant), N_REQ);
        pick  = ID_W'(r.idx);
        found = r.found;
    end

endmodule

// File: rtl/ladybird_stream_arbiter.sv
// ladybird_stream_arbiter: packet-locked round-robin arbiter for N_REQ valid/ready streams.
// Define LADYBIRD_ARB_STATS_EN to add saturating per-requester packet counters (pkt_count).
module ladybird_stream_arbiter
    import ladybird_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    anrst,
    input  logic                    nrst,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    input  logic [N_REQ-1:0]        s_valid,
    input  logic [N_REQ-1:0]        s_last,
    output logic [N_REQ-1:0]        s_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
`ifdef LADYBIRD_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]  pkt_count
`endif
);

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || CNT_W < 1) begin : g_bad_cfg
        $error("ladybird_stream_arbiter: N_REQ must be 2..8 and CNT_W >= 1");
    end

    arb_state_t      state, state_nx;
    logic [ID_W-1:0] last_grant, pick;
    logic            found, done;

    ladybird_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (s_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .found      (found)
    );

    always_comb begin
        busy     = state == ARB_LOCKED;
        m_valid  = busy & s_valid[grant_id];
        m_data   = s_data[grant_id*DATA_W +: DATA_W];
        m_last   = s_last[grant_id];
        s_ready  = busy ? (N_REQ'(m_ready) << grant_id) : '0;
        done     = m_valid & m_ready & m_last;
        state_nx = (state == ARB_IDLE) ? (found ? ARB_LOCKED : ARB_IDLE)
                                       : (done ? ARB_IDLE : ARB_LOCKED);
    end

    // Resetting last_grant to N_REQ-1 gives requester 0 first priority.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (!nrst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            state <= state_nx;
            if (state == ARB_IDLE && found) grant_id <= pick;
            if (done) last_grant <= grant_id;
        end
    end

`ifdef LADYBIRD_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) cnt <= '{default: '0};
        else if (!nrst) cnt <= '{default: '0};
        else if (done && cnt[grant_id] != '1) cnt[grant_id] <= cnt[grant_id] + 1'b1;
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign pkt_count[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_ladybird_stream_arbiter.sv
// tb_ladybird_stream_arbiter: directed checks of reset, locking, round-robin, backpressure and clear.
module tb_ladybird_stream_arbiter;

    logic        clk = 1'b0;
    logic        anrst, nrst;
    logic [7:0]  d [4];
    logic [31:0] s_data;
    logic [3:0]  s_valid, s_last, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef LADYBIRD_ARB_STATS_EN
    logic [7:0]  pkt_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign s_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    ladybird_stream_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(2)) dut (
        .clk      (clk),
        .anrst    (anrst),
        .nrst     (nrst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef LADYBIRD_ARB_STATS_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] got [5];
    logic [7:0] exp4 [5];
    int n, idx1, src;

    initial begin
        anrst = 1'b0; nrst = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0;
        d = '{default: 8'h00};
        #12 anrst = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step;
            check("rst_m_valid", m_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_grant_id", grant_id, 0);
        end

        d[2] = 8'hA1; s_valid = 4'b0100; m_ready = 1'b1;
        #1;
        check("single_arb_busy", busy, 0);
        check("single_arb_s_ready", s_ready, 0);
        step;
        check("single_busy", busy, 1);
        check("single_grant", grant_id, 2);
        check("single_m_valid", m_valid, 1);
        check("single_d1", m_data, 8'hA1);
        check("single_s_ready", s_ready, 4'b0100);
        d[2] = 8'hA2;
        step;
        check("single_d2", m_data, 8'hA2);
        check("single_last0", m_last, 0);
        d[2] = 8'hA3; s_last[2] = 1'b1;
        #1;
        check("single_d3", m_data, 8'hA3);
        check("single_last1", m_last, 1);
        step;
        check("single_idle_busy", busy, 0);
        check("single_idle_m_valid", m_valid, 0);
        check("single_grant_kept", grant_id, 2);
        s_valid = '0; s_last = '0;
        step;
        check("single_stay_idle", busy, 0);

        nrst = 1'b0;
        step;
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
        s_valid = 4'hF; s_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step;
            check("rr_busy", busy, 1);
            check("rr_grant", grant_id, k % 4);
            check("rr_data", m_data, 8'h10 + 8'(k % 4));
            check("rr_valid", m_valid, 1);
            step;
            check("rr_gap_busy", busy, 0);
        end
        s_valid = '0; s_last = '0;

        d[1] = 8'hB0; d[0] = 8'hC0; s_last = 4'b0001; s_valid = 4'b0011;
        exp4 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0};
        n = 0; idx1 = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            m_ready = (c % 2) == 0;
            #1;
            if (n < 4) check("bp_s_ready0", s_ready[0], 0);
            src = -1;
            if (m_valid && m_ready) begin
                got[n] = m_data;
                n++;
                src = int'(grant_id);
            end
            step;
            if (src == 1) begin
                idx1++;
                if (idx1 == 4) s_valid[1] = 1'b0;
                else begin
                    d[1] = 8'hB0 + 8'(idx1);
                    s_last[1] = idx1 == 3;
                end
            end
            if (src == 0) s_valid[0] = 1'b0;
        end
        check("bp_beat_count", n, 5);
        for (int i = 0; i < 5; i++) check("bp_beat", (i < n) ? got[i] : 8'hXX, exp4[i]);
        s_valid = '0; s_last = '0; m_ready = 1'b1;

        d[3] = 8'hD0; s_valid = 4'b1000;
        step;
        check("bub_busy", busy, 1);
        check("bub_grant", grant_id, 3);
        check("bub_data", m_data, 8'hD0);
        step;
        s_valid = 4'b0001; d[0] = 8'hE0; s_last[0] = 1'b1; d[3] = 8'hD1;
        for (int c = 0; c < 5; c++) begin
            step;
            check("bub_hold_busy", busy, 1);
            check("bub_hold_grant", grant_id, 3);
            check("bub_hold_s_ready0", s_ready[0], 0);
            check("bub_hold_m_valid", m_valid, 0);
        end
        s_valid[3] = 1'b1; nrst = 1'b0;
        step;
        nrst = 1'b1;
        check("clr_busy", busy, 0);
        check("clr_m_valid", m_valid, 0);
        check("clr_s_ready", s_ready, 0);
        step;
        check("clr_next_busy", busy, 1);
        check("clr_next_grant", grant_id, 0);
        check("clr_next_data", m_data, 8'hE0);
        s_valid = '0; s_last = '0;
        step;

`ifdef LADYBIRD_ARB_STATS_EN
        begin
            logic [1:0] expc [5];
            expc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            nrst = 1'b0;
            step;
            nrst = 1'b1;
            check("stat_clear", pkt_count, 0);
            d[1] = 8'h55; s_valid = 4'b0010; s_last = 4'b0010; m_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step;
                step;
                check("stat_cnt1", pkt_count[3:2], expc[k]);
                check("stat_others", {pkt_count[7:4], pkt_count[1:0]}, 0);
            end
            s_valid = '0; s_last = '0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ladybird_stream_arbiter.md
Name: ladybird_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one downstream valid/ready stream among N_REQ requester streams. Typical downstream: the shared ladybird FIFO feeding the UART/debug TX path.
- Once a requester is granted, the grant is held until that requester's beat carrying `last` completes. Packets from different requesters are never interleaved.
- Sits between producers (core MMIO, debug unit, DMA) and a single FIFO write port.

Parameters:
- N_REQ, 4, number of requester streams (2..8).
- DATA_W, 8, data width per beat.
- ID_W, $clog2(N_REQ), width of the grant index (derived localparam, not overridable).
- CNT_W, 16, statistics counter width (used only when the optional feature is enabled).

Ports:
- clk  in  1  clock, rising edge.
- anrst  in  1  reset, asynchronous, active-low.
- nrst  in  1  synchronous clear, active-low. Same effect as anrst, but sampled on clk.
- s_data  in  N_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- s_valid  in  N_REQ  per-requester beat valid.
- s_last  in  N_REQ  per-requester end-of-packet marker, qualified by s_valid.
- s_ready  out  N_REQ  per-requester ready.
- m_data  out  DATA_W  data of the granted requester.
- m_valid  out  1  downstream valid.
- m_last  out  1  end-of-packet of the granted requester.
- m_ready  in  1  downstream ready (e.g. FIFO a_ready).
- grant_id  out  ID_W  index of the current owner. Valid only while busy=1.
- busy  out  1  high while in state LOCKED.

Behaviour:
- Reset (anrst low, or nrst low at a clock edge):
  - state=IDLE, last_grant=N_REQ-1 (so requester 0 has first priority).
  - grant_id=0, busy=0, m_valid=0, s_ready=0.
- State IDLE:
  - m_valid=0 and all s_ready=0; no beat transfers.
  - If any s_valid is high, select the first set index searching upward from last_grant+1, wrapping modulo N_REQ.
  - Register the selection into grant_id and move to LOCKED. This costs exactly one arbitration cycle.
- State LOCKED, owner g:
  - m_data=s_data[g], m_valid=s_valid[g], m_last=s_last[g]. These are combinational passthrough, no added latency.
  - s_ready[g]=m_ready; all other s_ready bits are 0.
  - A beat transfers when s_valid[g] & m_ready.
  - If the transferred beat has s_last[g]=1: next state IDLE, last_grant<=g.
  - Otherwise stay LOCKED. The owner may drop s_valid between beats and the grant is still held (bubbles allowed, no timeout).
- Single-beat packets (s_last=1 on the first beat) are legal. Each packet costs 1 arbitration cycle plus its beats.
- Fairness: with all N_REQ requesters continuously valid, packets are granted in the order 0,1,...,N_REQ-1,0,...
- A requester asserting s_valid while another requester owns the grant waits. Its s_ready stays 0 and its data must stay stable (standard valid/ready rule).
- If requests arrive only in the same cycle as a release, they are not granted in that cycle. IDLE is always visited for one cycle between packets.
- If nrst is asserted mid-packet, the arbiter returns to IDLE immediately and the partial packet is abandoned. Downstream handles truncation; no recovery logic here.
- m_data and m_last are don't-care while m_valid=0.
- N_REQ=1 is not supported; an elaboration-time assertion enforces N_REQ>=2.

Optional Feature:
- Macro: LADYBIRD_ARB_STATS_EN.
- Defined:
  - Adds output port pkt_count (N_REQ*CNT_W): per-requester count of completed packets, i.e. transferred beats with last=1.
  - Counters saturate at all-ones and do not wrap.
  - Cleared by anrst and nrst.
  - Incremented in the same edge as the IDLE transition.
- Undefined: the port and counters are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- Package ladybird_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_LOCKED};
  - function rr_pick(req, last_grant) returning the next index plus a found flag.
- Sub-module ladybird_rr_picker:
  - combinational rotate/priority-encode of the N_REQ request vector against last_grant;
  - reusable for future bus arbiters.
- The FSM, muxing and optional counters stay in ladybird_stream_arbiter.

Test Plan:
- Reset then idle: after anrst release, all s_valid=0 for 10 cycles -> m_valid=0, busy=0, s_ready=0, grant_id=0 throughout.
- Single requester: req2 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), m_ready=1 -> busy one cycle after s_valid; m_data sequence A1,A2,A3; IDLE for 1 cycle after; grant_id=2.
- Round-robin: all 4 requesters hold single-beat packets (data=0x10+i) continuously -> grant order 0,1,2,3,0; m_data 0x10,0x11,0x12,0x13,0x10; one beat every 2 cycles.
- No interleave and backpressure:
  - req1 sends a 4-beat packet while req0 is valid; m_ready toggles 1,0,1,0.
  - Required: all 4 req1 beats precede any req0 beat, and no beat is duplicated or lost.
  - Required: s_ready[0]=0 throughout.
- Owner bubble and mid-packet clear:
  - req3 drops s_valid for 5 cycles mid-packet -> busy stays 1 and grant_id=3; req0 is not granted.
  - Then nrst=0 for 1 cycle -> next cycle busy=0; next grant goes to requester 0.
- With LADYBIRD_ARB_STATS_EN, CNT_W=2: req1 sends 5 single-beat packets -> pkt_count[1] reads 1,2,3,3,3; other counts stay 0.
